// File: rtl/irq_timer_bank.sv
// irq_timer_bank: line-derived tick, masked interrupt channels and ROM bank register.
// A tick advances every 2^LSTEP video lines. Each channel fires on the rising edge of a
// chosen tick bit and is routed to either cpu_nmi or cpu_irq. STICKY selects legacy
// one-tick level mode or held-until-acknowledged mode.
// Optional feature macro: IRQ_STATUS_RD_EN adds a registered status read of IRQP at
// STAT_ADDR; without it RDDV/RDDT are tied low.
module irq_timer_bank #(
  parameter int unsigned      NCH       = 3,
  parameter int unsigned      VW        = 9,
  parameter int unsigned      LSTEP     = 4,
  parameter int unsigned      TICKW     = 9,
  parameter logic [NCH*4-1:0] CH_SEL    = {4'd4, 4'd3, 4'd0},
  parameter logic [NCH-1:0]   NMI_MAP   = 3'b001,
  parameter bit               STICKY    = 1'b0,
  parameter int unsigned      BANKW     = 3,
  parameter int unsigned      BANK_LSB  = 5,
  parameter logic [15:0]      MASK_ADDR = 16'hE044,
  parameter logic [15:0]      BANK_ADDR = 16'hF000,
  parameter logic [15:0]      ACK_ADDR  = 16'hE045,
  parameter logic [15:0]      STAT_ADDR = 16'hE046
) (
  input  logic             CPUCL,
  input  logic             RESET,
  input  logic [VW-1:0]    PV,
  input  logic [15:0]      CPUAD,
  input  logic [7:0]       CPUWD,
  input  logic             CPUWE,
  input  logic             CPURE,
  output logic             cpu_irq,
  output logic             cpu_nmi,
  output logic [NCH-1:0]   IRQP,
  output logic [BANKW-1:0] ROMBK,
  output logic             RDDV,
  output logic [7:0]       RDDT
);

  // Line-event tracking and tick counter
  logic [VW-1:0]    ppv_q, ppv_d;
  logic             sync_q, sync_d;
  logic [TICKW-1:0] tick_q, tick_d;
  logic [TICKW-1:0] tick_inc;
  logic [TICKW-1:0] rise;

  // Channel state
  logic [NCH-1:0]   mask_q, mask_d;
  logic [NCH-1:0]   irqp_q, irqp_d;
  logic [NCH-1:0]   fire;
  logic             irq_q, irq_d;
  logic             nmi_q, nmi_d;

  // Bank register
  logic [BANKW-1:0] rombk_q, rombk_d;

  // Bus decode
  logic             wr_mask;
  logic             wr_ack;
  logic             wr_bank;
  logic             ev;
  logic             ev_take;

  // Inputs not fully consumed by the decode (CPUWD has bits outside mask/bank fields).
  logic             unused_sig;
  assign unused_sig = ^{CPUWD, CPURE, STAT_ADDR};

  // Decode bus writes; ack only exists in sticky mode.
  always_comb begin
    wr_mask = CPUWE && (CPUAD == MASK_ADDR);
    wr_bank = CPUWE && (CPUAD == BANK_ADDR);
    wr_ack  = STICKY && CPUWE && (CPUAD == ACK_ADDR);
  end

  // Line event: a new line whose low LSTEP bits are zero. A coincident mask/ack write
  // defers it; pPV is then left stale so the event is seen again next cycle.
  always_comb begin
    ev      = (PV != ppv_q) && (PV[LSTEP-1:0] == '0);
    ev_take = ev && !wr_mask && !wr_ack;
  end

  // Tick bits that go 0->1 on the next increment, and the channels they trigger.
  always_comb begin
    tick_inc = tick_q + TICKW'(1);
    rise     = ~tick_q & tick_inc;
    fire     = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      for (int unsigned b = 0; b < TICKW; b++) begin
        if (CH_SEL[4*i +: 4] == 4'(b)) begin
          fire[i] = rise[b];
        end
      end
    end
  end

  // Next state for tick, pPV, mask and pending bits.
  always_comb begin
    ppv_d  = ppv_q;
    sync_d = sync_q;
    tick_d = tick_q;
    mask_d = mask_q;
    irqp_d = irqp_q;

    if (ev_take) begin
      ppv_d = PV;
      // First event at line 0 after reset re-aligns the tick to the frame.
      if (sync_q && (PV == '0)) begin
        tick_d = '0;
        sync_d = 1'b0;
      end else begin
        tick_d = tick_inc;
      end
      if (STICKY) begin
        irqp_d = irqp_q | (fire & mask_q);
      end else begin
        irqp_d = fire & mask_q;
      end
    end

    if (wr_mask) begin
      mask_d = CPUWD[NCH-1:0];
      irqp_d = irqp_q & CPUWD[NCH-1:0];
    end

    if (wr_ack) begin
      irqp_d = irqp_q & ~CPUWD[NCH-1:0];
    end
  end

  // Interrupt lines follow the pending bits registered in the same cycle.
  always_comb begin
    nmi_d = |(irqp_d & NMI_MAP);
    irq_d = |(irqp_d & ~NMI_MAP);
  end

  // Bank register: independent of all other activity.
  always_comb begin
    rombk_d = rombk_q;
    if (wr_bank) begin
      rombk_d = CPUWD[BANK_LSB +: BANKW];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CPUCL) begin
    if (RESET) begin
      ppv_q   <= VW'(1);
      sync_q  <= 1'b1;
      tick_q  <= '0;
      mask_q  <= '0;
      irqp_q  <= '0;
      irq_q   <= 1'b0;
      nmi_q   <= 1'b0;
      rombk_q <= '0;
    end else begin
      ppv_q   <= ppv_d;
      sync_q  <= sync_d;
      tick_q  <= tick_d;
      mask_q  <= mask_d;
      irqp_q  <= irqp_d;
      irq_q   <= irq_d;
      nmi_q   <= nmi_d;
      rombk_q <= rombk_d;
    end
  end

  assign IRQP    = irqp_q;
  assign cpu_irq = irq_q;
  assign cpu_nmi = nmi_q;
  assign ROMBK   = rombk_q;

`ifdef IRQ_STATUS_RD_EN
  logic       rd_stat;
  logic       rddv_q, rddv_d;
  logic [7:0] rddt_q, rddt_d;

  assign rd_stat = CPURE && (CPUAD == STAT_ADDR);

  // Status response: pending bits zero-extended, one cycle after the read; non-destructive.
  always_comb begin
    rddv_d = rd_stat;
    rddt_d = '0;
    if (rd_stat) begin
      rddt_d[NCH-1:0] = irqp_q;
    end
  end

  // Status read registers.
  always_ff @(posedge CPUCL) begin
    if (RESET) begin
      rddv_q <= 1'b0;
      rddt_q <= '0;
    end else begin
      rddv_q <= rddv_d;
      rddt_q <= rddt_d;
    end
  end

  assign RDDV = rddv_q;
  assign RDDT = rddt_q;
`else
  assign RDDV = 1'b0;
  assign RDDT = 8'h00;
`endif

endmodule
